// File: rtl/pid_dispatch_ctrl.sv
// Pops PIDs from the PID-order FIFO one at a time and dispatches each packet to the
// key-load or data-encrypt path, holding the next PID until done or timeout.
module pid_dispatch_ctrl #(
  parameter logic [7:0]  KEY_PID  = 8'hC3,
  parameter logic [7:0]  DATA_PID = 8'h4B,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             pid_empty,
  input  logic [7:0]       pid_r_data,
  output logic             pid_r_enable,
  output logic             key_start,
  input  logic             key_done,
  output logic             data_start,
  input  logic             data_done,
  output logic             key_loaded,
  output logic             busy,
  output logic             bad_pid,
  output logic             timeout_err,
  output logic [CNT_W-1:0] job_count
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StKeyWait,
    StDataWait
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pid_q, pid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] job_q, job_d;
  logic             key_loaded_q, key_loaded_d;
  logic             pid_valid;

  // Upper nibble must be the bitwise complement of the lower nibble.
  assign pid_valid = (pid_q[7:4] == ~pid_q[3:0]);

  always_comb begin
    state_d      = state_q;
    pid_d        = pid_q;
    cnt_d        = cnt_q;
    job_d        = job_q;
    key_loaded_d = key_loaded_q;
    pid_r_enable = 1'b0;
    key_start    = 1'b0;
    data_start   = 1'b0;
    bad_pid      = 1'b0;
    timeout_err  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!pid_empty) state_d = StFetch;
      end
      StFetch: begin
        if (!pid_empty) begin
          pid_r_enable = 1'b1;
          pid_d        = pid_r_data;
          state_d      = StDecode;
        end else begin
          state_d = StIdle;
        end
      end
      StDecode: begin
        cnt_d = '0;
        if (pid_valid && pid_q == KEY_PID) begin
          key_start = 1'b1;
          state_d   = StKeyWait;
        end else if (pid_valid && pid_q == DATA_PID && key_loaded_q) begin
          data_start = 1'b1;
          state_d    = StDataWait;
        end else begin
          bad_pid = 1'b1;
          state_d = StIdle;
        end
      end
      StKeyWait: begin
        if (key_done) begin
          job_d        = job_q + CNT_W'(1);
          key_loaded_d = 1'b1;
          state_d      = StIdle;
        end else if (cnt_q == LAST) begin
          timeout_err  = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDataWait: begin
        if (data_done) begin
          job_d   = job_q + CNT_W'(1);
          state_d = StIdle;
        end else if (cnt_q == LAST) begin
          timeout_err = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // No pop or pulse may escape during a reset cycle.
    if (n_rst) begin
      pid_r_enable = 1'b0;
      key_start    = 1'b0;
      data_start   = 1'b0;
      bad_pid      = 1'b0;
      timeout_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= StIdle;
      pid_q        <= '0;
      cnt_q        <= '0;
      job_q        <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pid_q        <= pid_d;
      cnt_q        <= cnt_d;
      job_q        <= job_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign key_loaded = key_loaded_q;
  assign job_count  = job_q;

endmodule

// File: tb/tb_pid_dispatch_ctrl.sv
// Directed bench for pid_dispatch_ctrl with a small PID FIFO model and TIMEOUT=8.
module tb_pid_dispatch_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        pid_empty;
  logic [7:0]  pid_r_data;
  logic        pid_r_enable;
  logic        key_start;
  logic        key_done = 1'b0;
  logic        data_start;
  logic        data_done = 1'b0;
  logic        key_loaded;
  logic        busy;
  logic        bad_pid;
  logic        timeout_err;
  logic [15:0] job_count;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int empty_pops = 0;
  int multi_pulse = 0;

  logic [7:0] fifo_mem [16];
  logic [4:0] rd = '0;
  logic [4:0] wr = '0;

  assign pid_empty  = (rd == wr);
  assign pid_r_data = fifo_mem[rd[3:0]];

  pid_dispatch_ctrl #(
    .KEY_PID (8'hC3),
    .DATA_PID(8'h4B),
    .TIMEOUT (TO),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .pid_empty   (pid_empty),
    .pid_r_data  (pid_r_data),
    .pid_r_enable(pid_r_enable),
    .key_start   (key_start),
    .key_done    (key_done),
    .data_start  (data_start),
    .data_done   (data_done),
    .key_loaded  (key_loaded),
    .busy        (busy),
    .bad_pid     (bad_pid),
    .timeout_err (timeout_err),
    .job_count   (job_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pid_r_enable) begin
      pops <= pops + 1;
      if (rd == wr) empty_pops <= empty_pops + 1;
      else rd <= rd + 5'd1;
    end
  end

  always @(negedge clk) begin
    if ($countones({key_start, data_start, bad_pid, timeout_err}) > 1)
      multi_pulse <= multi_pulse + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pid(input logic [7:0] v);
    fifo_mem[wr[3:0]] = v;
    wr = wr + 5'd1;
  endtask

  // kind: 0 key job, 1 data job, 2 dropped. done_at: wait cycle carrying done (0 = never).
  task automatic job(input logic [7:0] pid, input int kind, input int done_at, input bit push);
    if (push) push_pid(pid);
    #1;
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_pop", {31'd0, pid_r_enable}, 0);
    tick();
    chk("fetch_pop", {31'd0, pid_r_enable}, 1);
    chk("fetch_busy", {31'd0, busy}, 1);
    tick();
    chk("dec_key_start", {31'd0, key_start}, (kind == 0) ? 1 : 0);
    chk("dec_data_start", {31'd0, data_start}, (kind == 1) ? 1 : 0);
    chk("dec_bad_pid", {31'd0, bad_pid}, (kind == 2) ? 1 : 0);
    chk("dec_pop", {31'd0, pid_r_enable}, 0);
    if (kind == 2) begin
      tick();
      chk("drop_idle", {31'd0, busy}, 0);
      return;
    end
    for (int w = 1; w <= TO; w++) begin
      tick();
      // The non-matching done on the first wait cycle must be ignored.
      key_done  = (kind == 0 && w == done_at) || (kind == 1 && w == 1 && done_at != 1);
      data_done = (kind == 1 && w == done_at) || (kind == 0 && w == 1 && done_at != 1);
      #1;
      chk("wait_busy", {31'd0, busy}, 1);
      chk("wait_timeout", {31'd0, timeout_err}, (done_at == 0 && w == TO) ? 1 : 0);
      chk("wait_no_start", {30'd0, key_start, data_start}, 0);
      if (w == done_at || (done_at == 0 && w == TO)) break;
    end
    tick();
    key_done  = 1'b0;
    data_done = 1'b0;
    #1;
    chk("end_idle", {31'd0, busy}, 0);
    chk("end_no_timeout", {31'd0, timeout_err}, 0);
  endtask

  initial begin
    repeat (2) tick();
    n_rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_key_loaded", {31'd0, key_loaded}, 0);
    chk("rst_job_count", {16'd0, job_count}, 0);
    chk("rst_pulses", {28'd0, key_start, data_start, bad_pid, timeout_err}, 0);
    chk("rst_pop", {31'd0, pid_r_enable}, 0);

    // Data PID before any key is dropped.
    job(8'h4B, 2, 0, 1'b1);
    chk("nokey_job_count", {16'd0, job_count}, 0);
    chk("nokey_key_loaded", {31'd0, key_loaded}, 0);

    // Key load, done on 5th wait cycle.
    job(8'hC3, 0, 5, 1'b1);
    chk("key_loaded_set", {31'd0, key_loaded}, 1);
    chk("key_job_count", {16'd0, job_count}, 1);

    job(8'h4B, 1, 3, 1'b1);
    chk("data_job_count", {16'd0, job_count}, 2);

    // Bad complement and valid-but-unexpected PIDs.
    job(8'hC4, 2, 0, 1'b1);
    job(8'h69, 2, 0, 1'b1);
    chk("bad_job_count", {16'd0, job_count}, 2);
    chk("bad_key_loaded", {31'd0, key_loaded}, 1);

    // Key timeout clears key_loaded; done on the last cycle still succeeds.
    job(8'hC3, 0, 0, 1'b1);
    chk("to_key_loaded", {31'd0, key_loaded}, 0);
    chk("to_job_count", {16'd0, job_count}, 2);
    job(8'hC3, 0, TO, 1'b1);
    chk("edge_key_loaded", {31'd0, key_loaded}, 1);
    chk("edge_job_count", {16'd0, job_count}, 3);

    // Preloaded FIFO drains in order.
    push_pid(8'hC3);
    push_pid(8'h4B);
    push_pid(8'h4B);
    job(8'hC3, 0, 3, 1'b0);
    job(8'h4B, 1, 3, 1'b0);
    job(8'h4B, 1, 3, 1'b0);
    chk("burst_job_count", {16'd0, job_count}, 6);
    chk("burst_drained", {31'd0, pid_empty}, 1);

    // Reset while in DATA_WAIT.
    push_pid(8'h4B);
    #1;
    tick();
    chk("r_fetch_pop", {31'd0, pid_r_enable}, 1);
    tick();
    chk("r_data_start", {31'd0, data_start}, 1);
    tick();
    chk("r_wait_busy", {31'd0, busy}, 1);
    n_rst = 1'b1;
    #1;
    chk("r_cycle_pulses", {27'd0, pid_r_enable, key_start, data_start, bad_pid, timeout_err}, 0);
    tick();
    n_rst = 1'b0;
    #1;
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_key_loaded", {31'd0, key_loaded}, 0);
    chk("r_job_count", {16'd0, job_count}, 0);
    data_done = 1'b1;
    tick();
    data_done = 1'b0;
    #1;
    chk("late_done_count", {16'd0, job_count}, 0);
    chk("late_done_busy", {31'd0, busy}, 0);
    job(8'h4B, 2, 0, 1'b1);
    chk("post_rst_count", {16'd0, job_count}, 0);

    tick();
    chk("total_pops", pops, 12);
    chk("empty_pops", empty_pops, 0);
    chk("pulse_exclusive", multi_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
